// File: rtl/fp_pkg.sv
// Shared definitions for the FP normalize/round stage: field widths, FSM states
// and the packed IEEE-754 single layout.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam int SIGN_POS = EXP_W + MAN_W;
  localparam int EXP_MSB  = EXP_W + MAN_W - 1;
  localparam int EXP_LSB  = MAN_W;
  localparam int FRAC_MSB = MAN_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_e;

  function automatic logic [SIGN_POS:0] pack_fp(input logic             sign,
                                                input logic [EXP_W-1:0] expo,
                                                input logic [MAN_W-1:0] frac);
    logic [SIGN_POS:0] word;
    word                   = '0;
    word[SIGN_POS]         = sign;
    word[EXP_MSB:EXP_LSB]  = expo;
    word[FRAC_MSB:0]       = frac;
    return word;
  endfunction

endpackage

// File: rtl/fp_lzc24.sv
// 24-bit leading-zero counter; an all-zero input reports 24.
module fp_lzc24 (
  input  logic [23:0] din,
  output logic [4:0]  count
);

  always_comb begin
    count = 5'd24;
    // NOTE: blocking '=' in combinational logic lets the highest set bit, visited last, win.
    for (int i = 0; i < 24; i++) begin
      if (din[i]) count = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Normalize + round-to-nearest-even stage after the mantissa adder.
// FP_NORM_FAST_EN selects a single-cycle LZC/barrel normalizer instead of 1 bit/cycle.
module fp_normalize_round #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [MAN_W+1:0]       mant_in,
  input  logic                   sign_in,
  input  logic [EXP_W-1:0]       exp_in,
  input  logic [2:0]             grs_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   inexact
);
  import fp_pkg::*;

  localparam int MW = MAN_W + 2;
  localparam int WE = EXP_W + 2;

  state_e                 state_q, state_d;
  logic [MW-1:0]          mant_q, mant_d;
  logic                   sign_q, sign_d;
  logic signed [WE-1:0]   exp_q, exp_d;
  logic [2:0]             grs_q, grs_d;
  logic [EXP_W+MAN_W:0]   result_q, result_d;
  logic                   overflow_q, overflow_d;
  logic                   inexact_q, inexact_d;

  logic                   round_up;
  logic [MW-1:0]          rnd_sum;
  logic [MAN_W:0]         rnd_mant;
  logic signed [WE-1:0]   rnd_exp;

`ifdef FP_NORM_FAST_EN
  logic [4:0]             lzc;
  logic [WE-1:0]          exp_m1;
  logic [4:0]             sh_amt;
  logic [MAN_W+2:0]       shifted;

  fp_lzc24 u_lzc (
    .din   (mant_q[MAN_W:0]),
    .count (lzc)
  );

  // The exponent floor caps the shift so subnormals stop at working exponent 1.
  always_comb begin
    exp_m1  = exp_q - WE'(1);
    sh_amt  = (exp_m1 < WE'(lzc)) ? exp_m1[4:0] : lzc;
    shifted = {mant_q[MAN_W:0], grs_q[2:1]} << sh_amt;
  end
`endif

  always_comb begin
    round_up = grs_q[2] & (grs_q[1] | grs_q[0] | mant_q[0]);
    rnd_sum  = {1'b0, mant_q[MAN_W:0]} + MW'(round_up);
    if (rnd_sum[MAN_W+1]) begin
      rnd_mant = rnd_sum[MAN_W+1:1];
      rnd_exp  = exp_q + WE'(1);
    end else begin
      rnd_mant = rnd_sum[MAN_W:0];
      rnd_exp  = exp_q;
    end
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch can leave one unassigned (no latch).
    state_d    = state_q;
    mant_d     = mant_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    grs_d      = grs_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    inexact_d  = inexact_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mant_d  = mant_in;
          sign_d  = sign_in;
          exp_d   = (exp_in == '0) ? WE'(1) : $signed({2'b00, exp_in});
          grs_d   = grs_in;
          state_d = NORM;
        end
      end

      NORM: begin
        if (mant_q == '0 && grs_q == '0) begin
          // Exact zero still passes through ROUND, which packs it as +0.
          sign_d  = 1'b0;
          state_d = ROUND;
        end else if (mant_q[MAN_W+1]) begin
          mant_d  = mant_q >> 1;
          grs_d   = {mant_q[0], grs_q[2], grs_q[1] | grs_q[0]};
          exp_d   = exp_q + WE'(1);
          state_d = ROUND;
`ifdef FP_NORM_FAST_EN
        end else begin
          mant_d  = {1'b0, shifted[MAN_W+2:2]};
          grs_d   = {shifted[1], shifted[0], grs_q[0]};
          exp_d   = exp_q - $signed(WE'(sh_amt));
          state_d = ROUND;
        end
`else
        end else if (mant_q[MAN_W] || exp_q <= WE'(1)) begin
          state_d = ROUND;
        end else begin
          mant_d  = {mant_q[MW-2:0], grs_q[2]};
          grs_d   = {grs_q[1], 1'b0, grs_q[0]};
          exp_d   = exp_q - WE'(1);
        end
`endif
      end

      ROUND: begin
        inexact_d = |grs_q;
        if (rnd_exp >= $signed({2'b00, EXP_MAX})) begin
          result_d   = pack_fp(sign_q, EXP_MAX, '0);
          overflow_d = 1'b1;
        end else begin
          result_d   = pack_fp(sign_q, rnd_mant[MAN_W] ? rnd_exp[EXP_W-1:0] : '0,
                               rnd_mant[MAN_W-1:0]);
          overflow_d = 1'b0;
        end
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset along with the state so result/flags read 0 after reset.
    if (!rst_n) begin
      state_q    <= IDLE;
      mant_q     <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      grs_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      inexact_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mant_q     <= mant_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      grs_q      <= grs_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      inexact_q  <= inexact_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed self-checking bench for fp_normalize_round; expected values are hand-computed.
module tb_fp_normalize_round;

`ifdef FP_NORM_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int MAX_WAIT = 40;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] mant_in;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [2:0]  grs_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        inexact;

  int n_tests = 0;
  int n_fail  = 0;

  fp_normalize_round dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant_in   (mant_in),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .grs_in    (grs_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .inexact   (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Drives one operand, measures latency, checks the result, optionally stalls, then hands off.
  task automatic run_op(input string tag, input logic [24:0] m, input logic s,
                        input logic [7:0] e, input logic [2:0] g,
                        input logic [31:0] want_res, input logic want_ovf,
                        input logic want_inx, input int k, input int hold);
    int lat;
    logic [31:0] held;
    @(negedge clk);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    mant_in  = m;
    sign_in  = s;
    exp_in   = e;
    grs_in   = g;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), FAST ? 32'd2 : 32'(2 + k));
    check({tag, " result"}, result, want_res);
    check({tag, " overflow"}, 32'(overflow), 32'(want_ovf));
    check({tag, " inexact"}, 32'(inexact), 32'(want_inx));
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, " hold result"}, result, held);
      check({tag, " hold valid/ready"}, {30'd0, out_valid, in_ready}, 32'b10);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " after handoff valid/ready"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mant_in   = '0;
    sign_in   = 1'b0;
    exp_in    = '0;
    grs_in    = '0;
    #1;
    check("reset state", {result, 27'd0, in_ready, out_valid, overflow, inexact, 1'b0},
          {32'd0, 27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //      tag            mant         s     exp     grs     result        ovf   inx   k  hold
    run_op("1p0+1p0",      25'h1000000, 1'b0, 8'd127, 3'b000, 32'h40000000, 1'b0, 1'b0, 0, 0);
    run_op("cancel",       25'h0200000, 1'b0, 8'd127, 3'b000, 32'h3E800000, 1'b0, 1'b0, 2, 5);
    run_op("rnd_carry",    25'h0FFFFFF, 1'b0, 8'd127, 3'b100, 32'h40000000, 1'b0, 1'b1, 0, 0);
    run_op("ovf_pos",      25'h1000000, 1'b0, 8'd254, 3'b000, 32'h7F800000, 1'b1, 1'b0, 0, 0);
    run_op("ovf_neg",      25'h1000000, 1'b1, 8'd254, 3'b000, 32'hFF800000, 1'b1, 1'b0, 0, 0);
    run_op("zero_neg",     25'h0000000, 1'b1, 8'd100, 3'b000, 32'h00000000, 1'b0, 1'b0, 0, 0);
    run_op("denorm",       25'h0000001, 1'b0, 8'd1,   3'b000, 32'h00000001, 1'b0, 1'b0, 0, 0);
    run_op("exp_in_zero",  25'h0000001, 1'b0, 8'd0,   3'b000, 32'h00000001, 1'b0, 1'b0, 0, 0);
    run_op("exp_clamp",    25'h0000001, 1'b0, 8'd3,   3'b000, 32'h00000004, 1'b0, 1'b0, 2, 0);
    run_op("tie_even",     25'h0800000, 1'b0, 8'd127, 3'b100, 32'h3F800000, 1'b0, 1'b1, 0, 0);
    run_op("tie_odd",      25'h0800001, 1'b0, 8'd127, 3'b100, 32'h3F800002, 1'b0, 1'b1, 0, 0);
    run_op("sticky_only",  25'h0800000, 1'b0, 8'd127, 3'b001, 32'h3F800000, 1'b0, 1'b1, 0, 0);
    run_op("denorm_carry", 25'h07FFFFF, 1'b0, 8'd1,   3'b100, 32'h00800000, 1'b0, 1'b1, 0, 0);
    run_op("rshift_stky",  25'h1000003, 1'b0, 8'd127, 3'b000, 32'h40000002, 1'b0, 1'b1, 0, 0);
    run_op("neg_shift1",   25'h0400000, 1'b1, 8'd127, 3'b000, 32'hBF000000, 1'b0, 1'b0, 1, 0);
    run_op("guard_in",     25'h0400000, 1'b0, 8'd127, 3'b100, 32'h3F000001, 1'b0, 1'b0, 1, 0);

    // Abort an operand while it is in NORM; the next one must be unaffected.
    @(negedge clk);
    in_valid = 1'b1;
    mant_in  = 25'h0200000;
    sign_in  = 1'b1;
    exp_in   = 8'd127;
    grs_in   = 3'b000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("mid-op reset valid/ready", {30'd0, out_valid, in_ready}, 32'b01);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset",  25'h1000000, 1'b0, 8'd127, 3'b000, 32'h40000000, 1'b0, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
